// File: rtl/mac_subset_mq.sv
// Multi-channel GMII-style transmit sequencer.
// Reads length-prefixed packets from a shared RAM and frames them with lead/trail slots.
module mac_subset_mq #(
  parameter int mac_aw     = 10,
  parameter int n_ch       = 2,
  parameter int big_endian = 0,
  parameter int lead       = 4,
  parameter int trail      = 4,
  parameter int ifg        = 24,
  parameter int guard      = 256
) (
  input  logic                   tx_clk,
  input  logic                   tx_rst,
  output logic [mac_aw-1:0]      host_raddr,
  input  logic [15:0]            host_rdata,
  input  logic [n_ch*mac_aw-1:0] buf_start_addr,
  input  logic [n_ch-1:0]        tx_mac_start,
  output logic [n_ch-1:0]        tx_mac_done,
  input  logic                   scanner_busy,
  output logic                   strobe_s,
  output logic                   strobe_l,
  output logic [7:0]             mac_data,
  output logic [2:0]             tx_chan
);

  typedef enum logic [2:0] {
    IDLE, LEN, HOLD, LEAD, DATA, TRAIL, GAP, DONE
  } state_t;

  localparam logic [15:0] LEAD_M1  = 16'(lead - 1);
  localparam logic [15:0] TRAIL_M1 = 16'(trail - 1);
  localparam logic [15:0] IFG_M1   = 16'((ifg > 0) ? ifg - 1 : 0);
  localparam logic [15:0] GUARD    = 16'(guard);

  state_t state, state_nxt;

  (* ASYNC_REG = "TRUE" *) logic [1:0] busy_sync;
  logic        busy_s;
  logic [15:0] idle_cnt;
  logic [15:0] cnt;
  logic [15:0] len_last;
  logic [10:0] len;
  logic        len_rdy;
  logic [2:0]  chan;
  logic [2:0]  last;
  logic [2:0]  sel;
  logic        found;
  logic [7:0]  elig;
  logic [3:0]  idx;
  logic        hi_sel;

  assign busy_s   = busy_sync[1];
  assign len_last = {5'b0, len} - 16'd1;

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      busy_sync <= 2'b00;
      idle_cnt  <= '0;
    end else begin
      busy_sync <= {busy_sync[0], scanner_busy};
      if (busy_s)
        idle_cnt <= '0;
      else if (idle_cnt != GUARD)
        idle_cnt <= idle_cnt + 16'd1;
    end
  end

  // Round-robin: search starts one past the last channel served.
  always_comb begin
    elig  = 8'(tx_mac_start & ~tx_mac_done);
    sel   = last;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= n_ch; i++) begin
      idx = 4'(last) + 4'(i);
      if (idx >= 4'(n_ch))
        idx = idx - 4'(n_ch);
      if (!found && elig[idx[2:0]]) begin
        found = 1'b1;
        sel   = idx[2:0];
      end
    end
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (found) state_nxt = LEN;
      LEN:   if (len_rdy)
               state_nxt = (host_rdata[10:0] == 11'd0) ? DONE : HOLD;
      HOLD:  if (idle_cnt == GUARD) state_nxt = LEAD;
      LEAD:  if (cnt == LEAD_M1) state_nxt = DATA;
      DATA:  if (cnt == len_last) state_nxt = TRAIL;
      TRAIL: if (cnt == TRAIL_M1) state_nxt = GAP;
      GAP:   if (cnt == IFG_M1) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      cnt         <= '0;
      len         <= '0;
      len_rdy     <= 1'b0;
      chan        <= '0;
      last        <= 3'(n_ch - 1);
      host_raddr  <= '0;
      tx_mac_done <= '0;
    end else begin
      cnt     <= (state != state_nxt) ? 16'd0 : cnt + 16'd1;
      len_rdy <= (state == LEN) && !len_rdy;
      if (state == IDLE && found) begin
        chan       <= sel;
        last       <= sel;
        host_raddr <= buf_start_addr[sel*mac_aw +: mac_aw];
      end
      if (state == LEN && len_rdy) begin
        len        <= host_rdata[10:0];
        host_raddr <= host_raddr + 1'b1;
      end
      // Advance after the first byte of a word; RAM latency covers the second.
      if (state == DATA && !cnt[0] && (cnt + 16'd2 < {5'b0, len}))
        host_raddr <= host_raddr + 1'b1;
      for (int k = 0; k < n_ch; k++) begin
        if (!tx_mac_start[k])
          tx_mac_done[k] <= 1'b0;
        if (state == DONE && chan == 3'(k))
          tx_mac_done[k] <= 1'b1;
      end
    end
  end

  assign strobe_l = state inside {LEAD, DATA, TRAIL};
  assign strobe_s = (state == DATA);
  assign tx_chan  = chan;
  assign hi_sel   = (big_endian != 0) ? ~cnt[0] : cnt[0];
  assign mac_data = !strobe_s ? 8'h00 :
                    hi_sel ? host_rdata[15:8] : host_rdata[7:0];

endmodule

// File: tb/tb_mac_subset_mq.sv
// Randomized bench for mac_subset_mq against a frame-level reference model.
// A monitor collapses strobes into frames; the model derives bytes from RAM contents.
module tb_mac_subset_mq;

  localparam int AW    = 10;
  localparam int NCH   = 2;
  localparam int LEAD  = 4;
  localparam int TRAIL = 4;
  localparam int IFG   = 24;
  localparam int GUARD = 256;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   raddr;
  logic [15:0]     rdata;
  logic [NCH*AW-1:0] bases;
  logic [NCH-1:0]  start;
  logic [NCH-1:0]  done;
  logic            busy;
  logic            ss;
  logic            sl;
  logic [7:0]      md;
  logic [2:0]      chan;

  logic [15:0] mem [0:1023];

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    int l;
    int s;
    int first;
    int chan;
    int gap;
  } frame_t;

  frame_t fq[$];
  int     bq[$];
  int     zero_err = 0;
  int     chan_err = 0;

  mac_subset_mq #(
    .mac_aw(AW), .n_ch(NCH), .big_endian(0),
    .lead(LEAD), .trail(TRAIL), .ifg(IFG), .guard(GUARD)
  ) dut (
    .tx_clk(clk),
    .tx_rst(rst),
    .host_raddr(raddr),
    .host_rdata(rdata),
    .buf_start_addr(bases),
    .tx_mac_start(start),
    .tx_mac_done(done),
    .scanner_busy(busy),
    .strobe_s(ss),
    .strobe_l(sl),
    .mac_data(md),
    .tx_chan(chan)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rdata <= mem[raddr];

  task automatic chk(string tag, int got, int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame monitor
  initial begin : mon
    bit     inf;
    int     gap;
    frame_t f;
    inf = 1'b0;
    gap = 1000;
    f   = '{0, 0, -1, 0, 0};
    forever begin
      @(negedge clk);
      if (sl) begin
        if (!inf) begin
          inf = 1'b1;
          f   = '{0, 0, -1, int'(chan), gap};
        end
        if (int'(chan) != f.chan) chan_err++;
        if (ss) begin
          if (f.first < 0) f.first = f.l;
          f.s++;
          bq.push_back(int'(md));
        end else if (md != 8'h00) begin
          zero_err++;
        end
        f.l++;
      end else begin
        if (ss || md != 8'h00) zero_err++;
        if (inf) begin
          inf = 1'b0;
          fq.push_back(f);
          gap = 1;
        end else begin
          gap++;
        end
      end
    end
  end

  function automatic int exp_byte(int base, int i);
    logic [15:0] w;
    w = mem[(base + 1 + i / 2) % 1024];
    return (i % 2 == 0) ? int'(w[7:0]) : int'(w[15:8]);
  endfunction

  task automatic load(int ch, int base, int len);
    bases[ch*AW +: AW] = AW'(base);
    mem[base] = {5'($urandom), 11'(len)};
    for (int w = 0; w < (len + 1) / 2; w++)
      mem[(base + 1 + w) % 1024] = 16'($urandom);
  endtask

  task automatic wait_done(int ch, int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done[ch]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ss(int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ss) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_pkt(int ch, int base, int len);
    frame_t f;
    int     b;
    if (fq.size() == 0) begin
      chk("frame_present", 0, 1);
      return;
    end
    f = fq.pop_front();
    chk("strobe_l_len", f.l, LEAD + len + TRAIL);
    chk("strobe_s_len", f.s, len);
    chk("lead_offset", f.first, LEAD);
    chk("tx_chan", f.chan, ch);
    chk("ifg_min", int'(f.gap >= IFG), 1);
    for (int i = 0; i < len; i++) begin
      b = (bq.size() > 0) ? bq.pop_front() : -1;
      chk("byte", b, exp_byte(base, i));
    end
  endtask

  task automatic run_loaded(int ch, int base, int len);
    bit ok;
    tick();
    start[ch] = 1'b1;
    wait_done(ch, GUARD + len + 200, ok);
    chk("done_set", int'(ok), 1);
    check_pkt(ch, base, len);
    start[ch] = 1'b0;
    tick();
    tick();
    chk("done_clr", int'(done[ch]), 0);
  endtask

  task automatic run_pkt(int ch, int base, int len);
    load(ch, base, len);
    run_loaded(ch, base, len);
  endtask

  task automatic run_pair(int first, int second, int b0, int b1);
    bit ok;
    load(0, b0, 60);
    load(1, b1, 60);
    tick();
    start = 2'b11;
    wait_done(first, GUARD + 300, ok);
    chk("pair_done_a", int'(ok), 1);
    wait_done(second, GUARD + 300, ok);
    chk("pair_done_b", int'(ok), 1);
    check_pkt(first, (first == 0) ? b0 : b1, 60);
    check_pkt(second, (second == 0) ? b0 : b1, 60);
    start = 2'b00;
    tick();
    tick();
    chk("pair_done_clr", int'(done), 0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int lat;
    int ch, base, len;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    rst   = 1'b1;
    start = '0;
    busy  = 1'b0;
    bases = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobe_l", int'(sl), 0);
    chk("rst_strobe_s", int'(ss), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_raddr", int'(raddr), 0);
    chk("rst_mac_data", int'(md), 0);
    chk("rst_tx_chan", int'(chan), 0);
    rst = 1'b0;

    // Reference packet: 11 22 33 44 55 from base 0x010
    bases[0 +: AW] = 10'h010;
    mem[16] = 16'h0005;
    mem[17] = 16'h2211;
    mem[18] = 16'h4433;
    mem[19] = 16'hA555;
    run_loaded(0, 16, 5);

    repeat (6) begin
      ch   = int'($urandom_range(0, 1));
      base = int'($urandom_range(0, 1023));
      len  = int'($urandom_range(1, 40));
      run_pkt(ch, base, len);
    end
    run_pkt(1, int'($urandom_range(0, 1023)), int'($urandom_range(1, 40)));

    // Last served ch1 -> ch0 first; then last served ch0 -> ch1 first
    run_pair(0, 1, 10'h100, 10'h200);
    run_pkt(0, 10'h300, 7);
    run_pair(1, 0, 10'h140, 10'h240);

    // Busy pulses every 200 cycles keep the packet parked
    load(0, 10'h050, 20);
    busy = 1'b1;
    tick();
    tick();
    start[0] = 1'b1;
    busy = 1'b0;
    for (int p = 0; p < 3; p++) begin
      repeat (198) tick();
      busy = 1'b1;
      tick();
      tick();
      busy = 1'b0;
    end
    busy = 1'b1;
    tick();
    chk("guard_blocks", fq.size() + int'(sl), 0);
    busy = 1'b0;
    lat = 0;
    while (!sl && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("guard_lat", int'(lat >= GUARD && lat <= GUARD + 8), 1);
    wait_done(0, 200, ok);
    chk("guard_done", int'(ok), 1);
    check_pkt(0, 10'h050, 20);
    start[0] = 1'b0;
    tick();
    tick();

    // Busy raised mid-DATA must not disturb the packet
    load(1, 10'h080, 30);
    start[1] = 1'b1;
    wait_ss(400, ok);
    chk("mid_data_start", int'(ok), 1);
    repeat (3) @(negedge clk);
    busy = 1'b1;
    wait_done(1, 200, ok);
    chk("mid_data_done", int'(ok), 1);
    check_pkt(1, 10'h080, 30);
    busy = 1'b0;
    start[1] = 1'b0;
    tick();
    tick();

    // Zero-length packet
    load(1, 10'h0C0, 0);
    tick();
    start[1] = 1'b1;
    wait_done(1, 50, ok);
    chk("len0_done", int'(ok), 1);
    chk("len0_no_frame", fq.size(), 0);
    start[1] = 1'b0;
    tick();
    tick();
    run_pkt(1, 10'h0D0, 1);

    // Address wrap
    run_pkt(0, 10'h3FE, 6);

    // Reset in DATA, then full resend
    load(0, 10'h120, 30);
    tick();
    start[0] = 1'b1;
    wait_ss(GUARD + 200, ok);
    chk("rst_pkt_start", int'(ok), 1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_sl", int'(sl), 0);
    chk("rst_mid_ss", int'(ss), 0);
    chk("rst_mid_done", int'(done[0]), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("rst_post_done", int'(done[0]), 0);
    fq.delete();
    bq.delete();
    wait_done(0, GUARD + 200, ok);
    chk("resend_done", int'(ok), 1);
    check_pkt(0, 10'h120, 30);
    start[0] = 1'b0;
    tick();
    tick();

    chk("idle_data_zero", zero_err, 0);
    chk("chan_stable", chan_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
